// File: rtl/seq_det_sched_if.sv
// Word/result handshakes plus the serial link to the pattern detector.
// slave = controller side, master = word source / result sink / detector side.
interface seq_det_sched_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              abort;
  logic              det_clr;
  logic              det_din;
  logic              det_hit;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_any;

  modport slave (
    input  in_valid, in_data, abort, det_hit, out_ready,
    output in_ready, det_clr, det_din, out_valid, out_count, out_any
  );

  modport master (
    output in_valid, in_data, abort, det_hit, out_ready,
    input  in_ready, det_clr, det_din, out_valid, out_count, out_any
  );
endinterface

// File: rtl/seq_det_sched.sv
// Shifts each accepted word MSB-first into a serial detector, counts hits that
// belong to real word bits and returns the per-word count over a handshake.
//
// state  | meaning
// IDLE   | detector held clear, waiting for a word
// SHIFT  | driving word bits to the detector, one per cycle
// DRAIN  | waiting DET_LAT cycles for the last bit's hit to arrive
// REPORT | count presented until the consumer takes it
module seq_det_sched #(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 2
) (
  input logic            clk,
  input logic            rst_n,
  seq_det_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

  localparam int MAXC = (WORD_W > DET_LAT) ? WORD_W : DET_LAT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [DET_LAT-1:0] qual_q, qual_d;
  logic [DET_LAT:0]   qual_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      qual_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      qual_q  <= qual_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    // qual_q[DET_LAT-1] lines up with det_hit: set only when that hit came from a word bit
    qual_ext = {qual_q, state_q == SHIFT};
    qual_d   = qual_ext[DET_LAT-1:0];

    if (bus.det_hit && qual_q[DET_LAT-1] && (hit_q != HIT_MAX))
      hit_d = hit_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          cnt_d   = CW'(WORD_W - 1);
          hit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          cnt_d   = CW'(DET_LAT - 1);
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = REPORT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      REPORT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      hit_d   = '0;
      qual_d  = '0;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.det_clr   = (state_q == IDLE);
  assign bus.det_din   = (state_q == SHIFT) & shreg_q[WORD_W-1];
  assign bus.out_valid = (state_q == REPORT);
  assign bus.out_count = hit_q;
  assign bus.out_any   = |hit_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched driving a non-overlapping 1101 Moore detector model
// (registered output, two-cycle latency); a second instance has CNT_W=1.
module tb_seq_det_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_det_sched_if #(.WORD_W(8), .CNT_W(4)) ifa ();
  seq_det_sched_if #(.WORD_W(8), .CNT_W(1)) ifb ();

  seq_det_sched #(.WORD_W(8), .CNT_W(4), .DET_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  seq_det_sched #(.WORD_W(8), .CNT_W(1), .DET_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // detector states: 0 idle, 1 "1", 2 "11", 3 "110", 4 "1101" (match, restarts fresh)
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd2 : 3'd0;
      3'd2:    return b ? 3'd2 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      default: return b ? 3'd1 : 3'd0;
    endcase
  endfunction

  logic [2:0] dsa = 3'd0, dsb = 3'd0;
  logic hita = 1'b0, hitb = 1'b0;
  always @(posedge clk) begin
    if (ifa.det_clr) begin dsa <= 3'd0; hita <= 1'b0; end
    else begin dsa <= det_next(dsa, ifa.det_din); hita <= (dsa == 3'd4); end
    if (ifb.det_clr) begin dsb <= 3'd0; hitb <= 1'b0; end
    else begin dsb <= det_next(dsb, ifb.det_din); hitb <= (dsb == 3'd4); end
  end
  assign ifa.det_hit = hita;
  assign ifb.det_hit = hitb;

  typedef struct { logic [3:0] cnt; logic any; } exp_t;
  exp_t sb[$];

  typedef struct { logic [7:0] word; logic [3:0] cnt; logic any; int stall; } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] c, input logic a);
    exp_t e;
    e.cnt = c;
    e.any = a;
    sb.push_back(e);
  endtask

  // Presents a word on ifa; returns with the word accepted (cycle T+1 negedge).
  task automatic accept_a(input logic [7:0] w, output bit ok, output int t_acc);
    ok = 0;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_data  = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifa.in_ready) ok = 1;
      else @(negedge clk);
    end
    t_acc = cyc;
    check("accept_wait", {31'd0, ok}, 32'd1);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifa.in_data  = '0;
  endtask

  task automatic run_word(input logic [7:0] w, input logic [3:0] ec, input logic ea, input int stall);
    bit ok;
    int t_acc;
    exp_t e;
    logic [3:0] held;
    accept_a(w, ok, t_acc);
    if (!ok) return;
    push_exp(ec, ea);
    for (int k = 0; k < 8; k++) begin
      check("shift_din", {31'd0, ifa.det_din}, {31'd0, w[7-k]});
      check("shift_clr", {31'd0, ifa.det_clr}, 32'd0);
      @(negedge clk);
    end
    check("drain_din", {31'd0, ifa.det_din}, 32'd0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifa.out_valid) ok = 1;
      else @(negedge clk);
    end
    check("report_wait", {31'd0, ok}, 32'd1);
    if (!ok) return;
    check("latency", cyc - t_acc, 32'd11);
    held = ifa.out_count;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", {31'd0, ifa.out_valid}, 32'd1);
      check("stall_count", {28'd0, ifa.out_count}, {28'd0, held});
      check("stall_in_ready", {31'd0, ifa.in_ready}, 32'd0);
      @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out_count", {28'd0, ifa.out_count}, {28'd0, e.cnt});
      check("out_any", {31'd0, ifa.out_any}, {31'd0, e.any});
    end
    @(negedge clk);
    ifa.out_ready = 1'b0;
    check("valid_drop", {31'd0, ifa.out_valid}, 32'd0);
    check("idle_ready", {31'd0, ifa.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t_acc;
    vecs[0] = '{8'b1101_1010, 4'd1, 1'b1, 0};
    vecs[1] = '{8'b1101_1101, 4'd2, 1'b1, 0};
    vecs[2] = '{8'hFF,        4'd0, 1'b0, 0};
    vecs[3] = '{8'h00,        4'd0, 1'b0, 0};
    vecs[4] = '{8'b1101_1010, 4'd1, 1'b1, 5};
    vecs[5] = '{8'b0000_1101, 4'd1, 1'b1, 0};
    vecs[6] = '{8'b0110_1101, 4'd1, 1'b1, 2};
    vecs[7] = '{8'b1111_1101, 4'd1, 1'b1, 0};

    ifa.in_valid = 0; ifa.in_data = '0; ifa.abort = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.abort = 0; ifb.out_ready = 0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    check("rst_det_clr", {31'd0, ifa.det_clr}, 32'd1);
    check("rst_det_din", {31'd0, ifa.det_din}, 32'd0);
    check("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("rst_out_count", {28'd0, ifa.out_count}, 32'd0);
    check("rst_out_any", {31'd0, ifa.out_any}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_word(vecs[v].word, vecs[v].cnt, vecs[v].any, vecs[v].stall);

    // abort in the 4th SHIFT cycle: word dropped, no report
    accept_a(8'b1101_1101, ok, t_acc);
    push_exp(4'd2, 1'b1);
    repeat (3) @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    void'(sb.pop_back());
    check("abort_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    check("abort_det_clr", {31'd0, ifa.det_clr}, 32'd1);
    check("abort_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("abort_count", {28'd0, ifa.out_count}, 32'd0);
    run_word(8'b1101_0000, 4'd1, 1'b1, 0);

    // reset pulsed while det_din is driving a 1 in the 2nd SHIFT cycle
    accept_a(8'b1101_1101, ok, t_acc);
    push_exp(4'd2, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("arst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    check("arst_det_clr", {31'd0, ifa.det_clr}, 32'd1);
    check("arst_det_din", {31'd0, ifa.det_din}, 32'd0);
    check("arst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("arst_out_count", {28'd0, ifa.out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(8'b1101_1101, 4'd2, 1'b1, 0);

    // CNT_W=1 instance: two hits saturate at 1
    @(negedge clk);
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'b1101_1101;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifb.in_ready) ok = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    ifb.in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifb.out_valid) ok = 1;
      else @(negedge clk);
    end
    check("sat_report_wait", {31'd0, ok}, 32'd1);
    check("sat_count", {31'd0, ifb.out_count}, 32'd1);
    check("sat_any", {31'd0, ifb.out_any}, 32'd1);
    ifb.out_ready = 1'b1;
    @(negedge clk);
    ifb.out_ready = 1'b0;
    check("sat_valid_drop", {31'd0, ifb.out_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
